// File: rtl/fu_dispatch_router.sv
// Issue-to-FU dispatch router: in-order acceptance into one FIFO per functional unit.
// Optional DISPATCH_STATS_EN adds saturating stall / same-FU-pair counters.

module fu_queue #(
    parameter int ISSUE_WIDTH = 2,
    parameter int PAYLOAD_W   = 64,
    parameter int QDEPTH      = 2,
    localparam int PTR_W      = $clog2(QDEPTH),
    localparam int OCC_W      = PTR_W + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [ISSUE_WIDTH-1:0]           enq_mask,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] enq_payload,
    input  logic                             deq_ready,
    output logic                             head_valid,
    output logic [PAYLOAD_W-1:0]             head_payload,
    output logic [OCC_W-1:0]                 occ
);
    logic [PAYLOAD_W-1:0]              mem [QDEPTH];
    logic [PTR_W-1:0]                  wptr, rptr;
    logic [OCC_W-1:0]                  enq_cnt;
    logic [ISSUE_WIDTH-1:0][PTR_W-1:0] wr_idx;
    logic                              deq;

    // Accepted slots take consecutive positions in ascending slot order.
    always_comb begin
        enq_cnt = '0;
        wr_idx  = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            wr_idx[i] = wptr + enq_cnt[PTR_W-1:0];
            if (enq_mask[i]) enq_cnt = enq_cnt + OCC_W'(1);
        end
    end

    assign head_valid   = (occ != '0);
    assign head_payload = head_valid ? mem[rptr] : '0;
    assign deq          = head_valid & deq_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            wptr <= wptr + enq_cnt[PTR_W-1:0];
            rptr <= rptr + PTR_W'(deq);
            occ  <= occ + enq_cnt - OCC_W'(deq);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < ISSUE_WIDTH; i++)
            if (enq_mask[i]) mem[wr_idx[i]] <= enq_payload[i*PAYLOAD_W +: PAYLOAD_W];
    end
endmodule

module fu_dispatch_router #(
    parameter int ISSUE_WIDTH = 2,
    parameter int FU_NUMBER   = 4,
    parameter int PAYLOAD_W   = 64,
    parameter int QDEPTH      = 2,
    localparam int FU_SEL_W   = $clog2(FU_NUMBER),
    localparam int OCC_W      = $clog2(QDEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [ISSUE_WIDTH-1:0]           issue_valid,
    input  logic [ISSUE_WIDTH*FU_SEL_W-1:0]  issue_fu,
    input  logic [ISSUE_WIDTH*PAYLOAD_W-1:0] issue_payload,
    output logic [ISSUE_WIDTH-1:0]           issue_ready,
    output logic [FU_NUMBER-1:0]             fu_valid,
    output logic [FU_NUMBER*PAYLOAD_W-1:0]   fu_payload,
    input  logic [FU_NUMBER-1:0]             fu_busy,
    output logic [FU_NUMBER*OCC_W-1:0]       q_occupancy
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      same_fu_pairs
`endif
);
    logic [ISSUE_WIDTH-1:0][FU_SEL_W-1:0] slot_fu;
    logic [FU_NUMBER-1:0][OCC_W-1:0]      occ;
    logic [FU_NUMBER-1:0][ISSUE_WIDTH-1:0] enq_mask;
    logic [ISSUE_WIDTH-1:0]               rdy;
    logic                                 prev_ok;
    int                                   same;

    assign slot_fu     = issue_fu;
    assign q_occupancy = occ;
    assign issue_ready = rdy;

    // Free space uses registered occupancy only, so fu_busy never reaches issue_ready.
    always_comb begin
        rdy     = '0;
        prev_ok = 1'b1;
        same    = 0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            same = 0;
            for (int j = 0; j < i; j++)
                if (issue_valid[j] && rdy[j] && slot_fu[j] == slot_fu[i]) same = same + 1;
            if (!flush && prev_ok && int'(slot_fu[i]) < FU_NUMBER)
                if (same < QDEPTH - int'(occ[slot_fu[i]])) rdy[i] = 1'b1;
            prev_ok = prev_ok && (!issue_valid[i] || rdy[i]);
        end
    end

    always_comb begin
        enq_mask = '0;
        for (int f = 0; f < FU_NUMBER; f++)
            for (int i = 0; i < ISSUE_WIDTH; i++)
                enq_mask[f][i] = issue_valid[i] & rdy[i] & (int'(slot_fu[i]) == f);
    end

    for (genvar f = 0; f < FU_NUMBER; f++) begin : g_fu
        fu_queue #(
            .ISSUE_WIDTH(ISSUE_WIDTH),
            .PAYLOAD_W  (PAYLOAD_W),
            .QDEPTH     (QDEPTH)
        ) u_q (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush),
            .enq_mask    (enq_mask[f]),
            .enq_payload (issue_payload),
            .deq_ready   (~fu_busy[f]),
            .head_valid  (fu_valid[f]),
            .head_payload(fu_payload[f*PAYLOAD_W +: PAYLOAD_W]),
            .occ         (occ[f])
        );
    end

`ifdef DISPATCH_STATS_EN
    logic stall_now, pair_now;

    // A mask with its lowest set bit cleared is nonzero iff two or more slots hit one FU.
    always_comb begin
        stall_now = !flush && |(issue_valid & ~rdy);
        pair_now  = 1'b0;
        for (int f = 0; f < FU_NUMBER; f++)
            if ((enq_mask[f] & (enq_mask[f] - ISSUE_WIDTH'(1))) != '0) pair_now = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            same_fu_pairs <= '0;
        end else begin
            if (stall_now && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (pair_now && same_fu_pairs != '1) same_fu_pairs <= same_fu_pairs + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fu_dispatch_router.sv
// Scoreboard bench for fu_dispatch_router: per-FU expected payload queues plus directed checks.

module tb_fu_dispatch_router;
    localparam int IW = 4;
    localparam int FN = 4;
    localparam int PW = 64;
    localparam int QD = 2;
    localparam int SW = 2;
    localparam int OW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic [IW-1:0]    issue_valid = '0;
    logic [IW*SW-1:0] issue_fu = '0;
    logic [IW*PW-1:0] issue_payload = '0;
    logic [IW-1:0]    issue_ready;
    logic [FN-1:0]    fu_valid;
    logic [FN*PW-1:0] fu_payload;
    logic [FN-1:0]    fu_busy = '0;
    logic [FN*OW-1:0] q_occupancy;
`ifdef DISPATCH_STATS_EN
    logic [31:0]      stall_cycles, same_fu_pairs;
`endif

    int checks = 0;
    int errors = 0;
    int m_stall = 0;
    int m_pairs = 0;
    logic [PW-1:0] sb [FN][$];

    fu_dispatch_router #(.ISSUE_WIDTH(IW), .FU_NUMBER(FN), .PAYLOAD_W(PW), .QDEPTH(QD)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_payload(issue_payload),
        .issue_ready(issue_ready), .fu_valid(fu_valid), .fu_payload(fu_payload),
        .fu_busy(fu_busy), .q_occupancy(q_occupancy)
`ifdef DISPATCH_STATS_EN
        , .stall_cycles(stall_cycles), .same_fu_pairs(same_fu_pairs)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [OW-1:0] occ_of(input int f);
        return q_occupancy[f*OW +: OW];
    endfunction

    function automatic logic [PW-1:0] pay_of(input int f);
        return fu_payload[f*PW +: PW];
    endfunction

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        issue_valid   = '0;
        issue_fu      = '0;
        issue_payload = '0;
    endtask

    task automatic set_slot(input int i, input logic [SW-1:0] fu, input logic [PW-1:0] pl);
        issue_valid[i]           = 1'b1;
        issue_fu[i*SW +: SW]     = fu;
        issue_payload[i*PW +: PW] = pl;
    endtask

    task automatic idle();
        begin_cycle();
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int f = 0; f < FN; f++) sb[f].delete();
    endtask

    // Compare issue_ready, then record what the DUT should accept at the coming edge.
    task automatic check_ready(input logic [IW-1:0] er, input string name);
        int cnt [FN];
        logic pair;
        @(negedge clk);
        checks++;
        if (issue_ready !== er) begin
            errors++;
            $display("FAIL %s ready: got %b exp %b", name, issue_ready, er);
        end
        for (int f = 0; f < FN; f++) cnt[f] = 0;
        for (int i = 0; i < IW; i++)
            if (issue_valid[i] && er[i]) begin
                sb[issue_fu[i*SW +: SW]].push_back(issue_payload[i*PW +: PW]);
                cnt[issue_fu[i*SW +: SW]]++;
            end
        pair = 1'b0;
        for (int f = 0; f < FN; f++) if (cnt[f] >= 2) pair = 1'b1;
        if (pair) m_pairs++;
        if (!flush && |(issue_valid & ~er)) m_stall++;
    endtask

    // Every dequeue must deliver the oldest outstanding payload for that FU.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && !flush)
                for (int f = 0; f < FN; f++)
                    if (fu_valid[f] && !fu_busy[f]) begin
                        checks++;
                        if (sb[f].size() == 0) begin
                            errors++;
                            $display("FAIL deq_fu%0d: got payload %h exp no entry", f, pay_of(f));
                        end else begin
                            logic [PW-1:0] e;
                            e = sb[f].pop_front();
                            if (pay_of(f) !== e) begin
                                errors++;
                                $display("FAIL deq_fu%0d: got %h exp %h", f, pay_of(f), e);
                            end
                        end
                    end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (fu_valid !== '0 || q_occupancy !== '0 || fu_payload !== '0 || issue_ready !== '1) begin
            errors++;
            $display("FAIL reset: got valid %b occ %h ready %b exp 0 0 1111", fu_valid, q_occupancy, issue_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_same_fu();
        begin_cycle();
        set_slot(0, 2'd2, 64'hA);
        set_slot(1, 2'd2, 64'hB);
        check_ready(4'b1111, "same_fu");
        checks++;
        if (fu_valid !== 4'b0000) begin
            errors++;
            $display("FAIL same_fu_bypass: got %b exp 0000", fu_valid);
        end
        idle();
        checks++;
        if (fu_valid !== 4'b0100 || occ_of(2) !== 2'd2) begin
            errors++;
            $display("FAIL same_fu_c1: got valid %b occ %0d exp 0100 2", fu_valid, occ_of(2));
        end
        idle();
        checks++;
        if (fu_valid !== 4'b0100 || occ_of(2) !== 2'd1) begin
            errors++;
            $display("FAIL same_fu_c2: got valid %b occ %0d exp 0100 1", fu_valid, occ_of(2));
        end
        idle();
        checks++;
        if (fu_valid !== 4'b0000 || q_occupancy !== '0) begin
            errors++;
            $display("FAIL same_fu_c3: got valid %b occ %h exp 0 0", fu_valid, q_occupancy);
        end
    endtask

    task automatic test_backpressure();
        begin_cycle();
        fu_busy = 4'b0010;
        set_slot(0, 2'd1, 64'h21);
        check_ready(4'b1111, "bp_c1");
        begin_cycle();
        set_slot(0, 2'd1, 64'h22);
        check_ready(4'b1111, "bp_c2");
        checks++;
        if (fu_valid[1] !== 1'b1 || pay_of(1) !== 64'h21 || occ_of(1) !== 2'd1) begin
            errors++;
            $display("FAIL bp_c2_head: got v%b %h occ %0d exp v1 21 1", fu_valid[1], pay_of(1), occ_of(1));
        end
        begin_cycle();
        set_slot(0, 2'd1, 64'h23);
        set_slot(1, 2'd3, 64'h24);
        check_ready(4'b0000, "bp_c3");
        checks++;
        if (pay_of(1) !== 64'h21 || occ_of(1) !== 2'd2) begin
            errors++;
            $display("FAIL bp_hold: got %h occ %0d exp 21 2", pay_of(1), occ_of(1));
        end
        begin_cycle();
        fu_busy = '0;
        @(negedge clk);
        checks++;
        if (occ_of(1) !== 2'd2 || fu_valid !== 4'b0010) begin
            errors++;
            $display("FAIL bp_drain0: got occ %0d valid %b exp 2 0010", occ_of(1), fu_valid);
        end
        idle();
        checks++;
        if (occ_of(1) !== 2'd1) begin
            errors++;
            $display("FAIL bp_drain1: got occ %0d exp 1", occ_of(1));
        end
        idle();
        checks++;
        if (occ_of(1) !== 2'd0 || fu_valid !== 4'b0000) begin
            errors++;
            $display("FAIL bp_drain2: got occ %0d valid %b exp 0 0000", occ_of(1), fu_valid);
        end
    endtask

    task automatic test_wide_issue();
        begin_cycle();
        set_slot(0, 2'd0, 64'h300);
        set_slot(1, 2'd1, 64'h301);
        set_slot(2, 2'd0, 64'h302);
        set_slot(3, 2'd0, 64'h303);
        check_ready(4'b0111, "wide");
        idle();
        checks++;
        if (occ_of(0) !== 2'd2 || occ_of(1) !== 2'd1 || fu_valid !== 4'b0011) begin
            errors++;
            $display("FAIL wide_c1: got occ0 %0d occ1 %0d valid %b exp 2 1 0011", occ_of(0), occ_of(1), fu_valid);
        end
        idle();
        checks++;
        if (occ_of(0) !== 2'd1 || fu_valid !== 4'b0001) begin
            errors++;
            $display("FAIL wide_c2: got occ0 %0d valid %b exp 1 0001", occ_of(0), fu_valid);
        end
        idle();
    endtask

    task automatic test_flush();
        begin_cycle();
        fu_busy = 4'b1000;
        set_slot(0, 2'd3, 64'h31);
        set_slot(1, 2'd3, 64'h32);
        check_ready(4'b1111, "flush_fill");
        begin_cycle();
        flush = 1'b1;
        set_slot(0, 2'd0, 64'h40);
        check_ready(4'b0000, "flush_cycle");
        checks++;
        if (occ_of(3) !== 2'd2) begin
            errors++;
            $display("FAIL flush_occ_before: got %0d exp 2", occ_of(3));
        end
        clear_model();
        begin_cycle();
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (fu_valid !== '0 || q_occupancy !== '0 || issue_ready !== '1) begin
            errors++;
            $display("FAIL flush_after: got valid %b occ %h ready %b exp 0 0 1111", fu_valid, q_occupancy, issue_ready);
        end
        fu_busy = '0;
    endtask

    task automatic test_async_reset();
        begin_cycle();
        fu_busy = 4'b0100;
        set_slot(0, 2'd2, 64'h51);
        set_slot(1, 2'd2, 64'h52);
        check_ready(4'b1111, "rst_fill");
        idle();
        checks++;
        if (occ_of(2) !== 2'd2) begin
            errors++;
            $display("FAIL rst_fill_occ: got %0d exp 2", occ_of(2));
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (fu_valid !== '0 || q_occupancy !== '0 || fu_payload !== '0 || issue_ready !== '1) begin
            errors++;
            $display("FAIL async_rst: got valid %b occ %h ready %b exp 0 0 1111", fu_valid, q_occupancy, issue_ready);
        end
        clear_model();
        m_stall = 0;
        m_pairs = 0;
        @(posedge clk);
        #3;
        rst_n   = 1'b1;
        fu_busy = '0;
        begin_cycle();
        set_slot(0, 2'd1, 64'h61);
        check_ready(4'b1111, "rst_after");
        idle();
        checks++;
        if (fu_valid !== 4'b0010 || occ_of(1) !== 2'd1) begin
            errors++;
            $display("FAIL rst_after_out: got valid %b occ %0d exp 0010 1", fu_valid, occ_of(1));
        end
        idle();
    endtask

    task automatic test_stats(input string name);
`ifdef DISPATCH_STATS_EN
        checks++;
        if (stall_cycles !== 32'(m_stall) || same_fu_pairs !== 32'(m_pairs)) begin
            errors++;
            $display("FAIL stats_%s: got stall %0d pairs %0d exp %0d %0d", name, stall_cycles, same_fu_pairs, m_stall, m_pairs);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_drained();
        idle();
        idle();
        for (int f = 0; f < FN; f++) begin
            checks++;
            if (sb[f].size() != 0) begin
                errors++;
                $display("FAIL drained_fu%0d: got %0d outstanding exp 0", f, sb[f].size());
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_same_fu();
        test_stats("same_fu");
        test_backpressure();
        test_stats("backpressure");
        test_wide_issue();
        test_flush();
        test_stats("flush");
        test_async_reset();
        test_stats("reset");
        test_drained();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
